instr_encoder: RTL and testbench

Sequential RISC-V encoder: the inverse of the instruction decode stage. Accepts micro-op requests keyed by the core's 6-bit `ex_type` code plus register and immediate fields, and emits 32-bit RV32IM instruction words with their target addresses on a registered valid/ready stream. It serves as the program loader for instruction memory and as the stimulus source for scoreboard benches. A `last` request appends a terminating `ecall`.

---
 rtl/instr_pkg.sv | 76 +++++++
 rtl/instr_encode_comb.sv | 63 ++++++
 rtl/instr_encoder.sv | 150 +++++++++++++++
 tb/tb_instr_encoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared constants for the RV32IM instruction encoder: ex_type codes, opcodes,
// funct7 values, the ecall word, FSM state type and small field packers.
package instr_pkg;

  localparam logic [5:0] EX_ADD   = 6'd0;
  localparam logic [5:0] EX_ADDI  = 6'd1;
  localparam logic [5:0] EX_SUB   = 6'd2;
  localparam logic [5:0] EX_AND   = 6'd3;
  localparam logic [5:0] EX_ANDI  = 6'd4;
  localparam logic [5:0] EX_OR    = 6'd5;
  localparam logic [5:0] EX_ORI   = 6'd6;
  localparam logic [5:0] EX_XOR   = 6'd7;
  localparam logic [5:0] EX_XORI  = 6'd8;
  localparam logic [5:0] EX_SLL   = 6'd9;
  localparam logic [5:0] EX_SLLI  = 6'd10;
  localparam logic [5:0] EX_SRL   = 6'd11;
  localparam logic [5:0] EX_SRLI  = 6'd12;
  localparam logic [5:0] EX_SRA   = 6'd13;
  localparam logic [5:0] EX_SRAI  = 6'd14;
  localparam logic [5:0] EX_SLT   = 6'd15;
  localparam logic [5:0] EX_SLTI  = 6'd16;
  localparam logic [5:0] EX_SLTU  = 6'd17;
  localparam logic [5:0] EX_SLTIU = 6'd18;
  localparam logic [5:0] EX_LUI   = 6'd19;
  localparam logic [5:0] EX_LB    = 6'd21;
  localparam logic [5:0] EX_LH    = 6'd22;
  localparam logic [5:0] EX_LW    = 6'd23;
  localparam logic [5:0] EX_LBU   = 6'd24;
  localparam logic [5:0] EX_LHU   = 6'd25;
  localparam logic [5:0] EX_SB    = 6'd26;
  localparam logic [5:0] EX_SH    = 6'd27;
  localparam logic [5:0] EX_SW    = 6'd28;
  localparam logic [5:0] EX_MUL   = 6'd29;
  localparam logic [5:0] EX_MULH  = 6'd30;
  localparam logic [5:0] EX_DIV   = 6'd31;
  localparam logic [5:0] EX_REM   = 6'd32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] ECALL = {25'd0, OP_SYSTEM};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ECALL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  // I-format shape; shift-immediates pass {funct7, shamt} as the 12-bit field.
  function automatic logic [31:0] enc_i(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic [11:0] imm12, input logic [4:0] rd,
                                        input logic [4:0] rs1);
    return {imm12, rs1, f3, rd, opcode};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [11:0] imm12,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OP_STORE};
  endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational field packer: maps one ex_type request to a 32-bit RV32IM word.
// valid_code is low (and instr zero) for codes with no encoding.
module instr_encode_comb
  import instr_pkg::*;
(
  input  logic [5:0]  ex_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [19:0] imm,
  output logic [31:0] instr,
  output logic        valid_code
);

  logic [11:0] imm12;
  logic [11:0] sh_base;
  logic [11:0] sh_alt;

  assign imm12   = imm[11:0];
  assign sh_base = {F7_BASE, imm[4:0]};
  assign sh_alt  = {F7_ALT, imm[4:0]};

  always_comb begin
    instr      = '0;
    valid_code = 1'b1;
    unique case (ex_type)
      EX_ADD:   instr = enc_r(F7_BASE, 3'b000, rd, rs1, rs2);
      EX_SLL:   instr = enc_r(F7_BASE, 3'b001, rd, rs1, rs2);
      EX_SLT:   instr = enc_r(F7_BASE, 3'b010, rd, rs1, rs2);
      EX_SLTU:  instr = enc_r(F7_BASE, 3'b011, rd, rs1, rs2);
      EX_XOR:   instr = enc_r(F7_BASE, 3'b100, rd, rs1, rs2);
      EX_SRL:   instr = enc_r(F7_BASE, 3'b101, rd, rs1, rs2);
      EX_OR:    instr = enc_r(F7_BASE, 3'b110, rd, rs1, rs2);
      EX_AND:   instr = enc_r(F7_BASE, 3'b111, rd, rs1, rs2);
      EX_SUB:   instr = enc_r(F7_ALT, 3'b000, rd, rs1, rs2);
      EX_SRA:   instr = enc_r(F7_ALT, 3'b101, rd, rs1, rs2);
      EX_MUL:   instr = enc_r(F7_MULDIV, 3'b000, rd, rs1, rs2);
      EX_MULH:  instr = enc_r(F7_MULDIV, 3'b001, rd, rs1, rs2);
      EX_DIV:   instr = enc_r(F7_MULDIV, 3'b100, rd, rs1, rs2);
      EX_REM:   instr = enc_r(F7_MULDIV, 3'b110, rd, rs1, rs2);
      EX_ADDI:  instr = enc_i(OP_I, 3'b000, imm12, rd, rs1);
      EX_SLTI:  instr = enc_i(OP_I, 3'b010, imm12, rd, rs1);
      EX_SLTIU: instr = enc_i(OP_I, 3'b011, imm12, rd, rs1);
      EX_XORI:  instr = enc_i(OP_I, 3'b100, imm12, rd, rs1);
      EX_ORI:   instr = enc_i(OP_I, 3'b110, imm12, rd, rs1);
      EX_ANDI:  instr = enc_i(OP_I, 3'b111, imm12, rd, rs1);
      EX_SLLI:  instr = enc_i(OP_I, 3'b001, sh_base, rd, rs1);
      EX_SRLI:  instr = enc_i(OP_I, 3'b101, sh_base, rd, rs1);
      EX_SRAI:  instr = enc_i(OP_I, 3'b101, sh_alt, rd, rs1);
      EX_LB:    instr = enc_i(OP_LOAD, 3'b000, imm12, rd, rs1);
      EX_LH:    instr = enc_i(OP_LOAD, 3'b001, imm12, rd, rs1);
      EX_LW:    instr = enc_i(OP_LOAD, 3'b010, imm12, rd, rs1);
      EX_LBU:   instr = enc_i(OP_LOAD, 3'b100, imm12, rd, rs1);
      EX_LHU:   instr = enc_i(OP_LOAD, 3'b101, imm12, rd, rs1);
      EX_SB:    instr = enc_s(3'b000, imm12, rs1, rs2);
      EX_SH:    instr = enc_s(3'b001, imm12, rs1, rs2);
      EX_SW:    instr = enc_s(3'b010, imm12, rs1, rs2);
      EX_LUI:   instr = {imm, rd, OP_LUI};
      default:  valid_code = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32IM encoder: accepts ex_type requests, emits encoded words with
// addresses through one output register stage, and appends ecall after req_last.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_ex_type,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [19:0]       req_imm,
  input  logic              req_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       count
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid & ready are both high; valid and payload must not change while
  // valid is high and ready is low.

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [15:0]         count_q, count_d;
  logic                err_q, err_d;
  logic                ecall_sent_q, ecall_sent_d;

  logic [31:0]         enc_instr;
  logic                enc_valid;
  logic                out_fire;
  logic                req_fire;
  logic                slot_free;

  instr_encode_comb u_encode (
    .ex_type    (req_ex_type),
    .rd         (req_rd),
    .rs1        (req_rs1),
    .rs2        (req_rs2),
    .imm        (req_imm),
    .instr      (enc_instr),
    .valid_code (enc_valid)
  );

  assign out_fire  = out_valid_q & out_ready;
  assign slot_free = ~out_valid_q | out_ready;
  assign req_ready = (state_q == ST_RUN) & slot_free;
  assign req_fire  = req_valid & req_ready;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    next_addr_d  = next_addr_q;
    count_d      = count_q;
    err_d        = err_q;
    ecall_sent_d = ecall_sent_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      count_d     = count_q + 16'd1;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          count_d      = '0;
          err_d        = 1'b0;
          next_addr_d  = BASE_ADDR;
          ecall_sent_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (req_fire) begin
          if (enc_valid) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(4);
          end else begin
            err_d = 1'b1;
          end
          if (req_last) state_d = ST_ECALL;
        end
      end
      ST_ECALL: begin
        // The ecall waits for the register to drain, then DONE follows its own accept.
        if (!ecall_sent_q) begin
          if (slot_free) begin
            out_valid_d  = 1'b1;
            out_instr_d  = ECALL;
            out_addr_d   = next_addr_q;
            next_addr_d  = next_addr_q + ADDR_W'(4);
            ecall_sent_d = 1'b1;
          end
        end else if (out_fire) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= BASE_ADDR;
      next_addr_q  <= BASE_ADDR;
      count_q      <= '0;
      err_q        <= 1'b0;
      ecall_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      next_addr_q  <= next_addr_d;
      count_q      <= count_d;
      err_q        <= err_d;
      ecall_sent_q <= ecall_sent_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign err       = err_q;
  assign busy      = (state_q == ST_RUN) | (state_q == ST_ECALL);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodes, back-pressure,
// invalid codes, reset mid-program and a random program against a scoreboard.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_ex_type = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [19:0] req_imm = '0;
  logic        req_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_ready = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;
  logic [31:0] exp_addr = BASE;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ex_type (req_ex_type),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .req_last    (req_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .count       (count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word_unexpected got addr %h instr %h, required none", out_addr, out_instr);
      end else begin
        exp_w = exp_q.pop_front();
        if ({out_addr, out_instr} !== exp_w) begin
          errors++;
          $display("FAIL out_word got addr %h instr %h, required addr %h instr %h",
                   out_addr, out_instr, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
  end

  // ---------------- reference encoder ----------------
  // fmt: 0 R, 1 I, 2 shift-imm, 3 load, 4 store, 5 lui
  function automatic bit model_enc(input logic [5:0] ex, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [19:0] imm, output logic [31:0] w);
    logic [12:0] t;
    bit ok;
    ok = 1'b1;
    t  = '0;
    w  = '0;
    case (ex)
      6'd0:  t = {3'd0, 3'd0, 7'h00};
      6'd1:  t = {3'd1, 3'd0, 7'h00};
      6'd2:  t = {3'd0, 3'd0, 7'h20};
      6'd3:  t = {3'd0, 3'd7, 7'h00};
      6'd4:  t = {3'd1, 3'd7, 7'h00};
      6'd5:  t = {3'd0, 3'd6, 7'h00};
      6'd6:  t = {3'd1, 3'd6, 7'h00};
      6'd7:  t = {3'd0, 3'd4, 7'h00};
      6'd8:  t = {3'd1, 3'd4, 7'h00};
      6'd9:  t = {3'd0, 3'd1, 7'h00};
      6'd10: t = {3'd2, 3'd1, 7'h00};
      6'd11: t = {3'd0, 3'd5, 7'h00};
      6'd12: t = {3'd2, 3'd5, 7'h00};
      6'd13: t = {3'd0, 3'd5, 7'h20};
      6'd14: t = {3'd2, 3'd5, 7'h20};
      6'd15: t = {3'd0, 3'd2, 7'h00};
      6'd16: t = {3'd1, 3'd2, 7'h00};
      6'd17: t = {3'd0, 3'd3, 7'h00};
      6'd18: t = {3'd1, 3'd3, 7'h00};
      6'd19: t = {3'd5, 3'd0, 7'h00};
      6'd21: t = {3'd3, 3'd0, 7'h00};
      6'd22: t = {3'd3, 3'd1, 7'h00};
      6'd23: t = {3'd3, 3'd2, 7'h00};
      6'd24: t = {3'd3, 3'd4, 7'h00};
      6'd25: t = {3'd3, 3'd5, 7'h00};
      6'd26: t = {3'd4, 3'd0, 7'h00};
      6'd27: t = {3'd4, 3'd1, 7'h00};
      6'd28: t = {3'd4, 3'd2, 7'h00};
      6'd29: t = {3'd0, 3'd0, 7'h01};
      6'd30: t = {3'd0, 3'd1, 7'h01};
      6'd31: t = {3'd0, 3'd4, 7'h01};
      6'd32: t = {3'd0, 3'd6, 7'h01};
      default: ok = 1'b0;
    endcase
    if (ok) begin
      case (t[12:10])
        3'd0: w = {t[6:0], rs2, rs1, t[9:7], rd, 7'h33};
        3'd1: w = {imm[11:0], rs1, t[9:7], rd, 7'h13};
        3'd2: w = {t[6:0], imm[4:0], rs1, t[9:7], rd, 7'h13};
        3'd3: w = {imm[11:0], rs1, t[9:7], rd, 7'h03};
        3'd4: w = {imm[11:5], rs2, rs1, t[9:7], imm[4:0], 7'h23};
        default: w = {imm, rd, 7'h37};
      endcase
    end
    return ok;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = BASE;
  endtask

  task automatic send(input logic [5:0] ex, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [19:0] imm, input logic last,
                      input logic [31:0] exp_instr, input bit exp_ok);
    bit acc;
    acc = 1'b0;
    req_ex_type = ex;
    req_rd      = rd;
    req_rs1     = rs1;
    req_rs2     = rs2;
    req_imm     = imm;
    req_last    = last;
    req_valid   = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        if (exp_ok) begin
          exp_q.push_back({exp_addr, exp_instr});
          exp_addr = exp_addr + 32'd4;
        end
        if (last) begin
          exp_q.push_back({exp_addr, 32'h0000_0073});
          exp_addr = exp_addr + 32'd4;
        end
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL req_accept got no accept in 64 cycles, required accept (ex %0d)", ex);
    end
  endtask

  task automatic wait_done(input logic [15:0] exp_count, input logic exp_err);
    bit seen;
    seen = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got done %b, required 1", done);
    end
    checks++;
    if (count !== exp_count) begin
      errors++;
      $display("FAIL final_count got %0d, required %0d", count, exp_count);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL final_err got %b, required %b", err, exp_err);
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got busy %b pending %0d, required busy 0 pending 0", busy, exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== BASE || req_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || count !== 16'd0) begin
      errors++;
      $display("FAIL %s got v%b i%h a%h rr%b b%b d%b e%b c%0d, required all zero / base",
               tag, out_valid, out_instr, out_addr, req_ready, busy, done, err, count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    check_reset_values("reset_values");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry got busy %b req_ready %b, required 1 1", busy, req_ready);
    end
    @(posedge clk); #1;
    send(6'd0, 5'd3, 5'd1, 5'd2, 20'h0, 1'b0, 32'h002081B3, 1'b1);
    send(6'd1, 5'd5, 5'd0, 5'd0, 20'hFFF, 1'b0, 32'hFFF00293, 1'b1);
    // start while running must not restart the address sequence
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send(6'd28, 5'd0, 5'd1, 5'd2, 20'h8, 1'b0, 32'h0020A423, 1'b1);
    send(6'd19, 5'd10, 5'd0, 5'd0, 20'h12345, 1'b0, 32'h12345537, 1'b1);
    send(6'd29, 5'd7, 5'd5, 5'd6, 20'h0, 1'b1, 32'h026283B3, 1'b1);
    wait_done(16'd6, 1'b0);
  endtask

  task automatic test_terminator();
    do_start();
    send(6'd14, 5'd4, 5'd4, 5'd0, 20'h3, 1'b1, 32'h40325213, 1'b1);
    wait_done(16'd2, 1'b0);
  endtask

  task automatic test_back_pressure();
    int c0;
    out_ready = 1'b0;
    do_start();
    send(6'd0, 5'd3, 5'd1, 5'd2, 20'h0, 1'b0, 32'h002081B3, 1'b1);
    req_ex_type = 6'd1; req_rd = 5'd5; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 20'hFFF;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== BASE || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable got v%b i%h a%h rr%b, required v1 i002081b3 a%h rr0",
                 out_valid, out_instr, out_addr, req_ready, BASE);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    c0 = cyc;
    send(6'd1, 5'd5, 5'd0, 5'd0, 20'hFFF, 1'b0, 32'hFFF00293, 1'b1);
    send(6'd28, 5'd0, 5'd1, 5'd2, 20'h8, 1'b0, 32'h0020A423, 1'b1);
    send(6'd19, 5'd10, 5'd0, 5'd0, 20'h12345, 1'b1, 32'h12345537, 1'b1);
    checks++;
    if (cyc - c0 != 3) begin
      errors++;
      $display("FAIL back_to_back got %0d cycles for 3 words, required 3", cyc - c0);
    end
    wait_done(16'd5, 1'b0);
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    do_start();
    send(6'd0, 5'd3, 5'd1, 5'd2, 20'h0, 1'b0, 32'h002081B3, 1'b1);
    send(6'd20, 5'd9, 5'd9, 5'd9, 20'h0, 1'b0, 32'h0, 1'b0);
    send(6'd1, 5'd5, 5'd0, 5'd0, 20'hFFF, 1'b1, 32'hFFF00293, 1'b1);
    wait_done(16'd3, 1'b1);
    // an invalid code flagged last still terminates the program
    do_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start got %b, required 0", err);
    end
    send(6'd29, 5'd7, 5'd5, 5'd6, 20'h0, 1'b0, 32'h026283B3, 1'b1);
    send(6'd45, 5'd1, 5'd1, 5'd1, 20'h0, 1'b1, 32'h0, 1'b0);
    wait_done(16'd2, 1'b1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    do_start();
    send(6'd0, 5'd3, 5'd1, 5'd2, 20'h0, 1'b0, 32'h002081B3, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending got out_valid %b, required 1", out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("reset_mid_values");
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_start();
    send(6'd1, 5'd5, 5'd0, 5'd0, 20'hFFF, 1'b1, 32'hFFF00293, 1'b1);
    wait_done(16'd2, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0]  ex;
    logic [4:0]  rd, rs1, rs2;
    logic [19:0] imm;
    logic [31:0] w;
    bit          ok;
    bit          any_bad;
    int          nvalid;
    any_bad = 1'b0;
    nvalid  = 0;
    do_start();
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ex  = 6'($urandom_range(0, 40));
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      imm = 20'($urandom_range(0, 20'hFFFFF));
      ok  = model_enc(ex, rd, rs1, rs2, imm, w);
      if (ok) nvalid++;
      else any_bad = 1'b1;
      send(ex, rd, rs1, rs2, imm, (i == 29), w, ok);
    end
    wait_done(16'(nvalid + 1), any_bad);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_terminator();
    test_back_pressure();
    test_invalid();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
